// File: rtl/clk_divider_pkg.sv
// Shared constants and the helpers that turn the division ratio into a
// legal half-period and a counter width.
package clk_divider_pkg;

  localparam int DEFAULT_COUNT = 10;

  // Half-period in input cycles. Ratios below 2 cannot be honoured, so they
  // fall back to divide-by-2 (half-period of one cycle). Odd ratios round
  // down to the nearest even period.
  function automatic int calc_half(input int count);
    return (count < 2) ? 1 : (count / 2);
  endfunction

  // Counter width: wide enough for HALF-1, and never narrower than one bit.
  function automatic int calc_cnt_w(input int half);
    return (half < 2) ? 1 : $clog2(half);
  endfunction

endpackage

// File: rtl/clk_divider_if.sv
// Output bundle of the divider: the divided clock plus a debug view of
// the phase counter so checkers can observe the internal phase.
interface clk_divider_if
  import clk_divider_pkg::*;
#(
  parameter int CNT_W = calc_cnt_w(calc_half(DEFAULT_COUNT))
);

  logic             out_clk;
  logic [CNT_W-1:0] dbg_cnt;

  // The divider drives everything; consumers only observe.
  modport master (output out_clk, output dbg_cnt);
  modport slave  (input  out_clk, input  dbg_cnt);

endinterface

// File: rtl/clk_divider.sv
// Divided clock generator: a phase counter running from 0 to HALF-1 and a
// single toggle flop that flips each time the counter wraps. The output
// comes straight from that flop, so it is glitch-free and has no
// combinational path from any input. After reset the output sits high for
// HALF edges, then low for HALF edges, and so on.
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int COUNT = DEFAULT_COUNT
) (
  input  logic          clk,
  input  logic          reset,
  clk_divider_if.master o_div
);

  // Legalised half-period and the counter sized to hold HALF-1.
  localparam int HALF  = calc_half(COUNT);
  localparam int CNT_W = calc_cnt_w(HALF);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_out_clk;
  logic             w_terminal;

  // Last cycle of the current half-period.
  assign w_terminal = (r_cnt == HALF_M1);

  // Phase counter: wraps at HALF-1, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_terminal) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Toggle flop: starts high out of reset, flips on every counter wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_clk <= 1'b1;
    end else if (w_terminal) begin
      r_out_clk <= ~r_out_clk;
    end
  end

  assign o_div.out_clk = r_out_clk;
  assign o_div.dbg_cnt = r_cnt;

  // The counter must never pass the wrap value.
  a_cnt_bound : assert property (@(posedge clk) disable iff (reset)
    r_cnt <= HALF_M1);

  // One reset edge is enough to land in the known start state.
  a_reset_state : assert property (@(posedge clk)
    reset |=> (r_out_clk && (r_cnt == '0)));

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: four instances (COUNT = 10, 2, 1, 7) share one
// clock and one reset. Inputs change and outputs are sampled on the
// falling edge, half a cycle away from the active edge.
module tb_clk_divider;
  import clk_divider_pkg::*;

  logic clk = 1'b0;
  logic reset;

  int n_total = 0;
  int n_bad   = 0;

  logic [0:0] exp_q[$];

  // Clock / reset block
  always #5 clk = ~clk;

  clk_divider_if #(.CNT_W(3)) if10 ();
  clk_divider_if #(.CNT_W(1)) if2  ();
  clk_divider_if #(.CNT_W(1)) if1  ();
  clk_divider_if #(.CNT_W(2)) if7  ();

  clk_divider #(.COUNT(10)) u_div10 (.clk(clk), .reset(reset), .o_div(if10));
  clk_divider #(.COUNT(2))  u_div2  (.clk(clk), .reset(reset), .o_div(if2));
  clk_divider #(.COUNT(1))  u_div1  (.clk(clk), .reset(reset), .o_div(if1));
  clk_divider #(.COUNT(7))  u_div7  (.clk(clk), .reset(reset), .o_div(if7));

  // Scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected output k edges after reset release: high for the first HALF
  // edges' worth of phase, then alternating every HALF edges.
  function automatic logic [31:0] exp_out(input int k, input int half);
    return ((k / half) % 2 == 0) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] exp_cnt(input int k, input int half);
    return 32'(k % half);
  endfunction

  // Driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_all(input int k, input string ph);
    check($sformatf("%s d10 out k=%0d", ph, k), 32'(if10.out_clk), exp_out(k, 5));
    check($sformatf("%s d10 cnt k=%0d", ph, k), 32'(if10.dbg_cnt), exp_cnt(k, 5));
    check($sformatf("%s d2 out k=%0d",  ph, k), 32'(if2.out_clk),  exp_out(k, 1));
    check($sformatf("%s d2 cnt k=%0d",  ph, k), 32'(if2.dbg_cnt),  exp_cnt(k, 1));
    check($sformatf("%s d1 out k=%0d",  ph, k), 32'(if1.out_clk),  exp_out(k, 1));
    check($sformatf("%s d1 cnt k=%0d",  ph, k), 32'(if1.dbg_cnt),  exp_cnt(k, 1));
    check($sformatf("%s d7 out k=%0d",  ph, k), 32'(if7.out_clk),  exp_out(k, 3));
    check($sformatf("%s d7 cnt k=%0d",  ph, k), 32'(if7.dbg_cnt),  exp_cnt(k, 3));
  endtask

  initial begin
    int  tog10, tog7, rise10, high10, len10, len7;
    logic prev10, prev7;
    logic [0:0] e;

    // Reset state
    reset = 1'b1;
    step();
    step();
    check_all(0, "rst");

    // Release and run 100 edges
    reset = 1'b0;
    check_all(0, "rel");

    // Hand-written divide-by-2 sequence for COUNT=2 and COUNT=1
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    tog10 = 0; tog7 = 0; rise10 = 0; high10 = 0; len10 = 0; len7 = 0;
    prev10 = 1'b1; prev7 = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      check_all(k, "run");
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("seq d2 k=%0d", k), 32'(if2.out_clk), 32'(e));
        check($sformatf("seq d1 k=%0d", k), 32'(if1.out_clk), 32'(e));
      end
      if (k == 5)  check("d10 first toggle", 32'(if10.out_clk), 32'd0);
      if (k == 10) check("d10 second toggle", 32'(if10.out_clk), 32'd1);
      len10++;
      len7++;
      if (if10.out_clk) high10++;
      if (if10.out_clk !== prev10) begin
        tog10++;
        if (if10.out_clk) rise10++;
        check($sformatf("d10 phase len k=%0d", k), 32'(len10), 32'd5);
        len10 = 0;
      end
      if (if7.out_clk !== prev7) begin
        tog7++;
        check($sformatf("d7 phase len k=%0d", k), 32'(len7), 32'd3);
        len7 = 0;
      end
      prev10 = if10.out_clk;
      prev7  = if7.out_clk;
    end
    check("d10 toggles in 100", 32'(tog10),  32'd20);
    check("d10 periods in 100", 32'(rise10), 32'd10);
    check("d10 high cycles",    32'(high10), 32'd50);
    check("d7 toggles in 100",  32'(tog7),   32'd33);

    // Reset in the middle of the low phase
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    check("mid d10 out before rst", 32'(if10.out_clk), 32'd0);
    check("mid d10 cnt before rst", 32'(if10.dbg_cnt), 32'd2);
    reset = 1'b1;
    step();
    check("mid d10 out after rst", 32'(if10.out_clk), 32'd1);
    check("mid d10 cnt after rst", 32'(if10.dbg_cnt), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_all(k, "restart");
    end
    check("restart d10 toggled at 5", 32'(if10.out_clk), 32'd0);

    // Reset held for four cycles
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_all(0, $sformatf("hold%0d", k));
    end
    reset = 1'b0;
    step();
    check_all(1, "post hold");

    // Final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
